// File: rtl/sincos_pkg.sv
// rtl/sincos_pkg.sv - shared Q1.15 types, constants and table helpers for the quarter-wave sin/cos generator
package sincos_pkg;

    typedef logic signed [15:0] q15_t;
    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_t;

    localparam q15_t Q15_MAX = 16'sd32767;

    function automatic q15_t q15_neg(input q15_t x);
        return (x == q15_t'(16'h8000)) ? Q15_MAX : -x;
    endfunction

    // round(32767*sin(k*pi/(2n))) by fixed-point Taylor series (2^30 scale), usable at elaboration.
    function automatic q15_t quarter_sin_entry(input int k, input int n);
        longint scale, x, term, sum;
        scale = longint'(1) << 30;
        x     = (longint'(k) * 64'sd3373259426) / (longint'(n) * 2);
        term  = x;
        sum   = x;
        for (int i = 1; i <= 8; i++) begin
            term = (term * x) / scale;
            term = (term * x) / scale;
            term = -term / longint'((2 * i) * (2 * i + 1));
            sum += term;
        end
        return q15_t'((sum * 32767 + scale / 2) / scale);
    endfunction

endpackage

// File: rtl/sincos_dp_rom.sv
// rtl/sincos_dp_rom.sv - dual-port quarter-sine ROM with read register (S1) and output register (S2)
module sincos_dp_rom
    import sincos_pkg::*;
#(
    parameter int ENTRIES = 256,
    localparam int ADDR_W = $clog2(ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    output q15_t              dout_a_o,
    output q15_t              dout_b_o
);
    function automatic logic [ENTRIES*16-1:0] build_table();
        logic [ENTRIES*16-1:0] t;
        t = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            t[k*16 +: 16] = quarter_sin_entry(k, ENTRIES);
        end
        return t;
    endfunction

    localparam logic [ENTRIES*16-1:0] TABLE = build_table();

    q15_t rd_a_q, rd_b_q, out_a_q, out_b_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else if (en_i) begin
            rd_a_q  <= TABLE[{addr_a_i, 4'd0} +: 16];
            rd_b_q  <= TABLE[{addr_b_i, 4'd0} +: 16];
            out_a_q <= rd_a_q;
            out_b_q <= rd_b_q;
        end
    end

    assign dout_a_o = out_a_q;
    assign dout_b_o = out_b_q;

endmodule

// File: rtl/sincos_quadrant_fold.sv
// rtl/sincos_quadrant_fold.sv - S0 stage: folds a full-circle angle onto quarter-table addresses and sign flags
module sincos_quadrant_fold
    import sincos_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [IDX_W+1:0] angle_i,
    output logic [IDX_W-1:0] sin_addr_o,
    output logic [IDX_W-1:0] cos_addr_o,
    output logic             sin_neg_o,
    output logic             cos_neg_o,
    output logic             sin_full_o,
    output logic             cos_full_o
);
    quadrant_t        quad;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] mirror;
    logic             mirror_full;
    logic [IDX_W-1:0] sin_addr_d, cos_addr_d, sin_addr_q, cos_addr_q;
    logic             sin_neg_d, cos_neg_d, sin_full_d, cos_full_d;
    logic             sin_neg_q, cos_neg_q, sin_full_q, cos_full_q;

    always_comb begin
        quad        = quadrant_t'(angle_i[IDX_W+1 -: 2]);
        idx         = angle_i[IDX_W-1:0];
        // N - idx wraps to address 0 at idx == 0; the full flag substitutes +max there.
        mirror      = -idx;
        mirror_full = (idx == '0);
        sin_addr_d  = idx;
        sin_full_d  = 1'b0;
        sin_neg_d   = 1'b0;
        cos_addr_d  = mirror;
        cos_full_d  = mirror_full;
        cos_neg_d   = 1'b0;
        unique case (quad)
            Q0: ;
            Q1: begin
                sin_addr_d = mirror;
                sin_full_d = mirror_full;
                cos_addr_d = idx;
                cos_full_d = 1'b0;
                cos_neg_d  = 1'b1;
            end
            Q2: begin
                sin_neg_d = 1'b1;
                cos_neg_d = 1'b1;
            end
            Q3: begin
                sin_addr_d = mirror;
                sin_full_d = mirror_full;
                sin_neg_d  = 1'b1;
                cos_addr_d = idx;
                cos_full_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sin_addr_q <= '0;
            cos_addr_q <= '0;
            sin_neg_q  <= 1'b0;
            cos_neg_q  <= 1'b0;
            sin_full_q <= 1'b0;
            cos_full_q <= 1'b0;
        end else if (en_i) begin
            sin_addr_q <= sin_addr_d;
            cos_addr_q <= cos_addr_d;
            sin_neg_q  <= sin_neg_d;
            cos_neg_q  <= cos_neg_d;
            sin_full_q <= sin_full_d;
            cos_full_q <= cos_full_d;
        end
    end

    assign sin_addr_o = sin_addr_q;
    assign cos_addr_o = cos_addr_q;
    assign sin_neg_o  = sin_neg_q;
    assign cos_neg_o  = cos_neg_q;
    assign sin_full_o = sin_full_q;
    assign cos_full_o = cos_full_q;

endmodule

// File: rtl/sincos_quarter_lut.sv
// rtl/sincos_quarter_lut.sv - 4-stage quarter-wave sin/cos generator with valid/ready on both sides
// Optional macro SINCOS_TAG_EN adds tag_in/tag_out carried alongside each result.
module sincos_quarter_lut
    import sincos_pkg::*;
#(
    parameter int ENTRIES = 256,
`ifdef SINCOS_TAG_EN
    parameter int TAG_W = 8,
`endif
    localparam int ANGLE_W = $clog2(ENTRIES) + 2
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [ANGLE_W-1:0] angle_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [15:0] sin_out,
    output logic signed [15:0] cos_out,
    output logic               out_valid,
    input  logic               out_ready
`ifdef SINCOS_TAG_EN
    ,
    input  logic [TAG_W-1:0]   tag_in,
    output logic [TAG_W-1:0]   tag_out
`endif
);
    localparam int IDX_W = ANGLE_W - 2;

    logic             advance;
    logic [2:0]       valid_q;
    logic             out_valid_q;
    logic [IDX_W-1:0] sin_addr, cos_addr;
    logic             sin_neg, cos_neg, sin_full, cos_full;
    logic [3:0]       flags_s1_q, flags_s2_q;
    q15_t             rom_sin, rom_cos;
    q15_t             sin_val, cos_val, sin_d, cos_d, sin_q, cos_q;

    // Whole pipeline moves as one; a stalled output freezes every stage.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    sincos_quadrant_fold #(.IDX_W(IDX_W)) u_fold (
        .clk_i      (clk_in),
        .rst_n_i    (rst_n_in),
        .en_i       (advance),
        .angle_i    (angle_in),
        .sin_addr_o (sin_addr),
        .cos_addr_o (cos_addr),
        .sin_neg_o  (sin_neg),
        .cos_neg_o  (cos_neg),
        .sin_full_o (sin_full),
        .cos_full_o (cos_full)
    );

    sincos_dp_rom #(.ENTRIES(ENTRIES)) u_rom (
        .clk_i    (clk_in),
        .rst_n_i  (rst_n_in),
        .en_i     (advance),
        .addr_a_i (sin_addr),
        .addr_b_i (cos_addr),
        .dout_a_o (rom_sin),
        .dout_b_o (rom_cos)
    );

    // flags_sN_q = {sin_neg, cos_neg, sin_full, cos_full}, aligned with the ROM read stages.
    always_comb begin
        sin_val = flags_s2_q[1] ? Q15_MAX : rom_sin;
        cos_val = flags_s2_q[0] ? Q15_MAX : rom_cos;
        sin_d   = flags_s2_q[3] ? q15_neg(sin_val) : sin_val;
        cos_d   = flags_s2_q[2] ? q15_neg(cos_val) : cos_val;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            flags_s1_q  <= '0;
            flags_s2_q  <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
        end else if (advance) begin
            valid_q     <= {valid_q[1:0], in_valid};
            out_valid_q <= valid_q[2];
            flags_s1_q  <= {sin_neg, cos_neg, sin_full, cos_full};
            flags_s2_q  <= flags_s1_q;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
        end
    end

    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign out_valid = out_valid_q;

`ifdef SINCOS_TAG_EN
    logic [TAG_W-1:0] tag_q [4];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 4; i++) tag_q[i] <= '0;
        end else if (advance) begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < 4; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[3];
`endif

endmodule

// File: tb/tb_sincos_quarter_lut.sv
// tb/tb_sincos_quarter_lut.sv - scoreboard bench for sincos_quarter_lut against an ideal sin/cos model
module tb_sincos_quarter_lut;
    localparam int  ENTRIES = 256;
    localparam int  ANGLE_W = 10;
    localparam real PI      = 3.14159265358979323846;

    logic               clk_in    = 1'b0;
    logic               rst_n_in  = 1'b0;
    logic [ANGLE_W-1:0] angle_in  = '0;
    logic               in_valid  = 1'b0;
    logic               in_ready;
    logic signed [15:0] sin_out;
    logic signed [15:0] cos_out;
    logic               out_valid;
    logic               out_ready = 1'b1;
`ifdef SINCOS_TAG_EN
    logic [7:0]         tag_in    = '0;
    logic [7:0]         tag_out;
`endif

    sincos_quarter_lut #(
        .ENTRIES (ENTRIES)
`ifdef SINCOS_TAG_EN
        , .TAG_W (8)
`endif
    ) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .angle_in  (angle_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SINCOS_TAG_EN
        , .tag_in  (tag_in),
        .tag_out   (tag_out)
`endif
    );

    typedef struct {
        int         angle;
        real        sin_i;
        real        cos_i;
        real        tol;
        bit         lat;
        int         acc;
        logic [7:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    always @(posedge clk_in) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input bit ok, input string detail);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic bit near(input logic signed [15:0] act, input real want, input real tol);
        real d;
        d = real'(act) - want;
        return (d <= tol) && (d >= -tol);
    endfunction

    // Monitor: hold/stall rules every cycle, scoreboard pop on each output transfer.
    logic signed [15:0] h_sin, h_cos;
    bit                 held = 1'b0;

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            held = 1'b0;
        end else begin
            if (held)
                chk("hold", out_valid && sin_out == h_sin && cos_out == h_cos,
                    $sformatf("got v=%0d sin=%0d cos=%0d want v=1 sin=%0d cos=%0d",
                              out_valid, sin_out, cos_out, h_sin, h_cos));
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", !in_ready, $sformatf("got in_ready=%0d want 0", in_ready));
                held  = 1'b1;
                h_sin = sin_out;
                h_cos = cos_out;
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1'b0,
                        $sformatf("got sin=%0d cos=%0d want no output", sin_out, cos_out));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("sin a=%0d", e.angle), near(sin_out, e.sin_i, e.tol),
                        $sformatf("got %0d want %f tol %f", sin_out, e.sin_i, e.tol));
                    chk($sformatf("cos a=%0d", e.angle), near(cos_out, e.cos_i, e.tol),
                        $sformatf("got %0d want %f tol %f", cos_out, e.cos_i, e.tol));
                    if (e.lat)
                        chk($sformatf("latency a=%0d", e.angle), (cyc - e.acc) == 4,
                            $sformatf("got %0d want 4", cyc - e.acc));
`ifdef SINCOS_TAG_EN
                    chk($sformatf("tag a=%0d", e.angle), tag_out == e.tag,
                        $sformatf("got %02h want %02h", tag_out, e.tag));
`endif
                end
            end
        end
    end

    // Drives one angle (in_valid left high for back-to-back use); returns at posedge+1.
    task automatic send(input int a, input real tol, input bit lat, input logic [7:0] tag);
        int   w;
        exp_t e;
        w        = 0;
        in_valid = 1'b1;
        angle_in = a[ANGLE_W-1:0];
`ifdef SINCOS_TAG_EN
        tag_in   = tag;
`endif
        @(negedge clk_in);
        while (!in_ready && w < 200) begin
            w++;
            @(negedge clk_in);
        end
        if (!in_ready) begin
            chk("send_timeout", 1'b0, $sformatf("got in_ready=0 for a=%0d want 1 within 200 cycles", a));
        end else begin
            e.angle = a;
            e.sin_i = 32767.0 * $sin(2.0 * PI * real'(a) / 1024.0);
            e.cos_i = 32767.0 * $cos(2.0 * PI * real'(a) / 1024.0);
            e.tol   = tol;
            e.lat   = lat;
            e.acc   = cyc;
            e.tag   = tag;
            sb.push_back(e);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int w;
        w        = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && w < 300) begin
            @(posedge clk_in);
            #1;
            w++;
        end
        chk(name, sb.size() == 0, $sformatf("got %0d pending want 0", sb.size()));
        idle(2);
    endtask

    initial begin
        int start;
        int cards[4];
        cards = '{0, 256, 512, 768};

        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_out_valid", out_valid == 1'b0, $sformatf("got %0d want 0", out_valid));
        chk("reset_sin", sin_out == 16'sd0, $sformatf("got %0d want 0", sin_out));
        chk("reset_cos", cos_out == 16'sd0, $sformatf("got %0d want 0", cos_out));
        chk("reset_in_ready", in_ready == 1'b1, $sformatf("got %0d want 1", in_ready));
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        foreach (cards[i]) begin
            send(cards[i], 0.5, 1'b1, 8'(i));
            idle(6);
        end
        drain("drain_cardinal");

        send(128, 0.5, 1'b0, 8'h01);
        send(896, 0.5, 1'b0, 8'h02);
        drain("drain_diagonal");

        start = cyc;
        for (int a = 0; a < 1024; a++) send(a, 1.0, 1'b0, 8'(a));
        chk("sweep_throughput", (cyc - start) == 1024, $sformatf("got %0d cycles want 1024", cyc - start));
        drain("drain_sweep");

        fork
            begin
                for (int i = 0; i < 6; i++) send(i * 150 + 7, 1.0, 1'b0, 8'(8'h40 + i));
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk_in);
                #2 rdy_mode = 2;
                repeat (5) @(posedge clk_in);
                #2 rdy_mode = 0;
            end
        join
        drain("drain_stall");

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(int'($urandom_range(0, 1023)), 1.0, 1'b0, 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        send(0, 0.5, 1'b0, 8'h11);
        send(1, 1.0, 1'b0, 8'h22);
        send(2, 1.0, 1'b0, 8'h33);
        rdy_mode = 0;
        drain("drain_random");

        send(100, 1.0, 1'b0, 8'h51);
        send(200, 1.0, 1'b0, 8'h52);
        send(300, 1.0, 1'b0, 8'h53);
        in_valid = 1'b0;
        rst_n_in = 1'b0;
        sb.delete();
        #1;
        chk("midreset_out_valid", out_valid == 1'b0, $sformatf("got %0d want 0", out_valid));
        chk("midreset_sin", sin_out == 16'sd0, $sformatf("got %0d want 0", sin_out));
        chk("midreset_cos", cos_out == 16'sd0, $sformatf("got %0d want 0", cos_out));
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        idle(8);
        send(640, 1.0, 1'b1, 8'h77);
        drain("drain_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
